// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/clear FSM, timebase prescaler, manual count gating
// and a time-multiplexed digit scan scheduler for the 7-segment display.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_stop,
    input  logic                  count_btn,
    input  logic                  clear,
    input  logic                  global_en,
    output logic [1:0]            state,
    output logic                  run,
    output logic                  cnt_en,
    output logic                  cnt_clr,
    output logic                  man_inc,
    output logic [2:0]            scan_sel,
    output logic [NUM_DIGITS-1:0] led_en
);

    localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0]        SEL_MAX  = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    state_t                  state_q,   state_d;
    logic [PRE_W-1:0]        pre_q,     pre_d;
    logic [SCAN_W-1:0]       scan_q,    scan_d;
    logic [2:0]              sel_q,     sel_d;
    logic                    run_q,     run_d;
    logic                    cnt_en_q,  cnt_en_d;
    logic                    cnt_clr_q, cnt_clr_d;
    logic                    man_inc_q, man_inc_d;
    logic [NUM_DIGITS-1:0]   led_q,     led_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            scan_q    <= '0;
            sel_q     <= '0;
            run_q     <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            man_inc_q <= 1'b0;
            led_q     <= '1;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            scan_q    <= scan_d;
            sel_q     <= sel_d;
            run_q     <= run_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            man_inc_q <= man_inc_d;
            led_q     <= led_d;
        end
    end

    // Next-state, prescaler and strobe logic; clear overrides every other request
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        man_inc_d = 1'b0;

        if (clear) begin
            cnt_clr_d = 1'b1;
            pre_d     = '0;
            state_d   = (state_q == ST_RUN) ? ST_RUN : ST_IDLE;
        end else begin
            man_inc_d = count_btn && (state_q != ST_RUN);
            // The pause edge itself still counts as a RUN cycle
            if (state_q == ST_RUN) begin
                if (pre_q == PRE_MAX) begin
                    pre_d    = '0;
                    cnt_en_d = 1'b1;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            if (start_stop) begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
        run_d = (state_d == ST_RUN);

        // Free-running scan slot counter, independent of the FSM
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            sel_d  = (sel_q == SEL_MAX) ? 3'd0 : sel_q + 3'd1;
        end else begin
            scan_d = scan_q + SCAN_W'(1);
            sel_d  = sel_q;
        end
        led_d = global_en ? ~(NUM_DIGITS'(1) << sel_q) : '1;
    end

    assign state    = state_q;
    assign run      = run_q;
    assign cnt_en   = cnt_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign man_inc  = man_inc_q;
    assign scan_sel = sel_q;
    assign led_en   = led_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a cycle-count based reference model.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV   = 10;
    localparam int SCAN_DIV   = 4;
    localparam int NUM_DIGITS = 8;
    localparam int S_IDLE     = 0;
    localparam int S_RUN      = 1;
    localparam int S_PAUSE    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       count_btn = 1'b0;
    logic       clear = 1'b0;
    logic       global_en = 1'b1;
    logic [1:0] state;
    logic       run;
    logic       cnt_en;
    logic       cnt_clr;
    logic       man_inc;
    logic [2:0] scan_sel;
    logic [7:0] led_en;

    stopwatch_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .count_btn  (count_btn),
        .clear      (clear),
        .global_en  (global_en),
        .state      (state),
        .run        (run),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .man_inc    (man_inc),
        .scan_sel   (scan_sel),
        .led_en     (led_en)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, RUN cycles since the last step/clear, cycles since reset
    int         m_state;
    int         run_cycles;
    int         cyc;
    logic       e_cnt_en, e_cnt_clr, e_man_inc;
    logic [7:0] e_led;
    int         e_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state    = S_IDLE;
        run_cycles = 0;
        cyc        = 0;
        e_cnt_en   = 1'b0;
        e_cnt_clr  = 1'b0;
        e_man_inc  = 1'b0;
        e_led      = 8'hFF;
        e_sel      = 0;
    endtask

    task automatic model_edge(input logic ss, input logic cb, input logic clr, input logic ge);
        logic [7:0] one;
        int         sel_before;
        one        = 8'd1;
        sel_before = (cyc / SCAN_DIV) % NUM_DIGITS;
        e_led      = ge ? ~(one << sel_before) : 8'hFF;
        cyc++;
        e_sel      = (cyc / SCAN_DIV) % NUM_DIGITS;
        e_cnt_en   = 1'b0;
        e_cnt_clr  = 1'b0;
        e_man_inc  = 1'b0;
        if (clr) begin
            e_cnt_clr  = 1'b1;
            run_cycles = 0;
            if (m_state != S_RUN) m_state = S_IDLE;
        end else begin
            e_man_inc = cb && (m_state != S_RUN);
            if (m_state == S_RUN) begin
                run_cycles++;
                if (run_cycles == TICK_DIV) begin
                    e_cnt_en   = 1'b1;
                    run_cycles = 0;
                end
            end
            if (ss) begin
                if (m_state == S_IDLE) begin
                    m_state    = S_RUN;
                    run_cycles = 0;
                end else if (m_state == S_RUN) begin
                    m_state = S_PAUSE;
                end else begin
                    m_state = S_RUN;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("state",    32'(state),    32'(m_state));
        chk("run",      32'(run),      32'(m_state == S_RUN));
        chk("cnt_en",   32'(cnt_en),   32'(e_cnt_en));
        chk("cnt_clr",  32'(cnt_clr),  32'(e_cnt_clr));
        chk("man_inc",  32'(man_inc),  32'(e_man_inc));
        chk("scan_sel", 32'(scan_sel), 32'(e_sel));
        chk("led_en",   32'(led_en),   32'(e_led));
    endtask

    // One clock: drive pulses, advance model at the edge, compare 1 time unit later
    task automatic step(input logic ss, input logic cb, input logic clr);
        start_stop = ss;
        count_btn  = cb;
        clear      = clr;
        @(posedge clk);
        model_edge(ss, cb, clr, global_en);
        #1;
        start_stop = 1'b0;
        count_btn  = 1'b0;
        clear      = 1'b0;
        check_all();
    endtask

    initial begin
        int n;
        int first;

        // Reset held for 20 cycles
        model_reset();
        repeat (20) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Start from IDLE, expect 5 steps in 50 cycles
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cnt_en) n++;
        end
        chk("cnt_en_in_50", 32'(n), 32'd5);

        // Pause 3 cycles after a step, hold 40 cycles, resume
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cnt_en) n++;
        end
        chk("cnt_en_in_pause", 32'(n), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cnt_en && first == 0) first = i;
        end
        chk("resume_latency", 32'(first), 32'd7);

        // Clear in RUN keeps running, pause, clear to IDLE, manual counts
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("idle_after_clear", 32'(state), 32'd0);
        n = 0;
        step(1'b0, 1'b1, 1'b0);
        if (man_inc) n++;
        step(1'b0, 1'b1, 1'b0);
        if (man_inc) n++;
        step(1'b0, 1'b0, 1'b0);
        chk("man_inc_idle", 32'(n), 32'd2);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("man_inc_run", 32'(man_inc), 32'd0);

        // Collisions: clear+start in IDLE, clear on the wrap cycle
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_beats_start", 32'(state), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("wrap_clear_en", 32'(cnt_en), 32'd0);
        chk("wrap_clear_clr", 32'(cnt_clr), 32'd1);

        // Scan walk with display on, then blanked, then on again
        global_en = 1'b1;
        repeat (40) step(1'b0, 1'b0, 1'b0);
        global_en = 1'b0;
        repeat (12) step(1'b0, 1'b0, 1'b0);
        global_en = 1'b1;
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Random button traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) global_en = ~global_en;
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 19) == 0));
        end

        // Async reset mid-RUN, asserted between edges
        global_en = 1'b1;
        if (m_state != S_RUN) begin
            if (m_state == S_PAUSE) step(1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        repeat (9) step(1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cnt_en) n++;
        end
        chk("no_cnt_en_after_reset", 32'(n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and scheduling block for the stopwatch display design. It turns debounced single-cycle button pulses into a run/pause/clear state machine. It generates the timebase enable and clear strobes that sequence the decimal time counter, and gates manual count pulses. It also time-multiplexes the eight 7-segment digits with a scan scheduler that honours the global display enable.

## Interface
- TICK_DIV, 1_000_000: clk cycles per time-counter step (10 ms at 100 MHz); must be at least 2.
- SCAN_DIV, 100_000: clk cycles per digit scan slot (1 ms at 100 MHz); must be at least 2.
- NUM_DIGITS, 8: number of multiplexed digits; must be at most 8.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- start_stop  in  1  debounced one-cycle pulse: toggles run/pause.
- count_btn  in  1  debounced one-cycle pulse: manual increment request.
- clear  in  1  debounced one-cycle pulse: synchronous soft clear.
- global_en  in  1  display enable level (SW0).
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE.
- run  out  1  high while in RUN.
- cnt_en  out  1  one-cycle step strobe to the time counter.
- cnt_clr  out  1  one-cycle clear strobe to the time counter.
- man_inc  out  1  one-cycle manual increment strobe.
- scan_sel  out  3  index of the digit currently driven.
- led_en  out  NUM_DIGITS  active-low one-hot digit enable.

## Operation
- All outputs are registered. Async reset sets the outputs to:
  - state=IDLE, run=0;
  - cnt_en=0, cnt_clr=0, man_inc=0;
  - scan_sel=0, led_en=all ones;
  - prescaler=0, scan counter=0.
- FSM transitions:
  - IDLE + start_stop → RUN; prescaler is 0.
  - RUN + start_stop → PAUSE; prescaler freezes at its current value.
  - PAUSE + start_stop → RUN; prescaler resumes from the frozen value.
  - clear in any state → cnt_clr pulse and prescaler forced to 0. RUN stays RUN; PAUSE and IDLE go to IDLE.
  - clear and start_stop in the same cycle: clear wins and start_stop is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - On reaching TICK_DIV-1 it wraps to 0 and cnt_en pulses.
  - The number of RUN cycles between consecutive cnt_en pulses is exactly TICK_DIV, with pause time excluded.
- Manual count:
  - count_btn in IDLE or PAUSE → man_inc pulse.
  - count_btn in RUN is ignored.
  - count_btn coincident with clear: man_inc suppressed.
- Scan scheduler:
  - The scan counter is free-running 0..SCAN_DIV-1 in all states.
  - On wrap, scan_sel advances modulo NUM_DIGITS (NUM_DIGITS-1 → 0).
  - led_en = ~(1 << scan_sel) when global_en=1, else all ones. The scan keeps advancing while the display is blanked.
- The block never issues cnt_en and cnt_clr in the same cycle; a clear on the wrap cycle suppresses that cnt_en.
- When rst_n is asserted mid-operation, all outputs return to their reset values immediately; no pending strobe survives.

## Timing
- start_stop sampled at edge E: run/state change is visible after E (latency 1).
- First cnt_en after start from IDLE: high for the single cycle after edge E+TICK_DIV.
- Pause at prescaler value p, then resume at edge R: next cnt_en follows edge R+(TICK_DIV-p).
- clear at edge E: cnt_clr high for the one cycle after E; state updates at the same edge.
- count_btn at edge E: man_inc high for the one cycle after E.
- scan_sel changes every SCAN_DIV cycles. led_en follows scan_sel and global_en with one cycle of register latency.
- Strobes are never stretched: back-to-back input pulses produce back-to-back output pulses.

## Test plan
All scenarios use TICK_DIV=10 and SCAN_DIV=4.
- Reset then start: hold rst_n=0 for 20 cycles, release, pulse start_stop → run=1 next cycle; cnt_en pulses every 10 cycles, 5 pulses in 50 cycles.
- Pause/resume: pause 3 cycles after a cnt_en, wait 40 cycles, resume → no cnt_en during the pause; next cnt_en 7 cycles after resume.
- Manual and clear: in IDLE, two count_btn pulses give two man_inc pulses. In RUN, count_btn gives no man_inc. clear in PAUSE gives cnt_clr=1 for one cycle and state=00.
- Collisions:
  - clear and start_stop in the same IDLE cycle: state stays 00 with one cnt_clr.
  - clear on the prescaler wrap cycle: cnt_clr=1 and no cnt_en.
- Scan:
  - global_en=1: led_en walks 11111110, 11111101, …, 01111111 with 4 cycles per digit, wrapping to digit 0 after 32 cycles.
  - global_en=0: led_en=11111111 one cycle later while scan_sel keeps advancing.
- Async reset mid-RUN: assert rst_n=0 between clock edges → all outputs return to their reset values before the next edge; no cnt_en after release until a new start_stop.
